// File: rtl/neuron_layer_sequencer.sv
// Layer sequencer: holds one layer of weights/biases and time-multiplexes a single
// shared dot-product neuron across NUM_NEURONS evaluations, collecting results in z_out.
module neuron_layer_sequencer #(
  parameter int INPUT_WIDTH = 3,
  parameter int NUM_NEURONS = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT     = 64,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int IW = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [NW-1:0]                           wr_neuron,
  input  logic [IW-1:0]                           wr_idx,
  input  logic signed [DATA_W-1:0]                wr_data,
  input  logic                                    start,
  input  logic [INPUT_WIDTH-1:0][DATA_W-1:0]      a_vec,
  output logic [INPUT_WIDTH-1:0][DATA_W-1:0]      n_a_in,
  output logic [INPUT_WIDTH-1:0][DATA_W-1:0]      n_w_in,
  output logic signed [DATA_W-1:0]                n_bias,
  output logic                                    n_valid_in,
  input  logic                                    n_valid_out,
  input  logic signed [DATA_W-1:0]                n_a_out,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_NEURONS-1:0][DATA_W-1:0]      z_out,
  output logic                                    timeout_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state;
  logic [NW-1:0]            k;
  logic [CW-1:0]            wait_cnt;
  logic signed [DATA_W-1:0] w_mem [NUM_NEURONS][INPUT_WIDTH];
  logic signed [DATA_W-1:0] b_mem [NUM_NEURONS];
  logic signed [DATA_W-1:0] act   [INPUT_WIDTH];
  logic                     wr_ok;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign n_valid_in = (state == S_ISSUE);
  assign wr_ok      = wr_en && !busy;

  // Operands come straight from registers that cannot change while busy,
  // so they stay stable from ISSUE through the end of WAIT.
  always_comb begin
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      n_a_in[i] = act[i];
      n_w_in[i] = w_mem[k][i];
    end
    n_bias = b_mem[k];
  end

  // Full decode against every slot; out-of-range indices simply match nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        b_mem[n] <= '0;
        for (int i = 0; i < INPUT_WIDTH; i++) w_mem[n][i] <= '0;
      end
    end else if (wr_ok) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (int'(wr_neuron) == n) begin
          if (int'(wr_idx) == INPUT_WIDTH) b_mem[n] <= wr_data;
          for (int i = 0; i < INPUT_WIDTH; i++)
            if (int'(wr_idx) == i) w_mem[n][i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      k           <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      z_out       <= '0;
      for (int i = 0; i < INPUT_WIDTH; i++) act[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < INPUT_WIDTH; i++) act[i] <= a_vec[i];
            z_out       <= '0;
            timeout_err <= 1'b0;
            k           <= '0;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (n_valid_out) begin
            z_out[k] <= n_a_out;
            state    <= S_STORE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_STORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_STORE: begin
          if (k == NW'(NUM_NEURONS - 1)) begin
            state <= S_DONE;
          end else begin
            k     <= k + 1'b1;
            state <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Bench for neuron_layer_sequencer: a behavioural neuron stub (dot product + bias,
// programmable latency, optional dropped response) and table-driven layer runs.
module tb_neuron_layer_sequencer;

  localparam int INPUT_WIDTH = 3;
  localparam int NUM_NEURONS = 4;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT     = 64;
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int IW = $clog2(INPUT_WIDTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [NW-1:0] wr_neuron = '0;
  logic [IW-1:0] wr_idx = '0;
  logic signed [DATA_W-1:0] wr_data = '0;
  logic start = 1'b0;
  logic [INPUT_WIDTH-1:0][DATA_W-1:0] a_vec = '0;
  logic [INPUT_WIDTH-1:0][DATA_W-1:0] n_a_in, n_w_in;
  logic signed [DATA_W-1:0] n_bias;
  logic n_valid_in, n_valid_out;
  logic signed [DATA_W-1:0] n_a_out;
  logic busy, done, timeout_err;
  logic [NUM_NEURONS-1:0][DATA_W-1:0] z_out;

  always #5 clk = ~clk;

  neuron_layer_sequencer #(
    .INPUT_WIDTH(INPUT_WIDTH), .NUM_NEURONS(NUM_NEURONS),
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .a_vec(a_vec), .n_a_in(n_a_in), .n_w_in(n_w_in),
    .n_bias(n_bias), .n_valid_in(n_valid_in), .n_valid_out(n_valid_out),
    .n_a_out(n_a_out), .busy(busy), .done(done), .z_out(z_out), .timeout_err(timeout_err)
  );

  // Neuron stub state and event monitors
  int lat = 1;
  int drop_idx = -1;
  int run_base = 0;
  int done_base = 0;
  int vin_total = 0;
  int vin_double = 0;
  int done_total = 0;
  int stub_cnt = 0;
  logic vin_prev = 1'b0;
  logic stub_vo = 1'b0;
  logic spur = 1'b0;
  logic signed [DATA_W-1:0] stub_val = '0;

  assign n_valid_out = stub_vo | spur;
  assign n_a_out     = spur ? 16'sh7777 : stub_val;

  function automatic logic [DATA_W-1:0] dot_ref(input logic [INPUT_WIDTH-1:0][DATA_W-1:0] a,
                                                input logic [INPUT_WIDTH-1:0][DATA_W-1:0] w,
                                                input logic [DATA_W-1:0] b);
    int s;
    s = int'($signed(b));
    for (int i = 0; i < INPUT_WIDTH; i++) s += int'($signed(a[i])) * int'($signed(w[i]));
    return s[DATA_W-1:0];
  endfunction

  always @(posedge clk) begin
    stub_vo <= 1'b0;
    if (n_valid_in) begin
      vin_total <= vin_total + 1;
      if (vin_total - run_base != drop_idx) begin
        stub_val <= dot_ref(n_a_in, n_w_in, n_bias);
        if (lat <= 1) stub_vo <= 1'b1;
        else stub_cnt <= lat - 1;
      end
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_vo <= 1'b1;
    end
    if (n_valid_in && vin_prev) vin_double <= vin_double + 1;
    vin_prev <= n_valid_in;
    if (done) done_total <= done_total + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic wr(input int n, input int idx, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_neuron = NW'(n); wr_idx = IW'(idx); wr_data = DATA_W'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  int w_def [NUM_NEURONS][INPUT_WIDTH] = '{'{4, 2, 3}, '{-1, -2, -3}, '{-2, 3, -4}, '{2, 4, -1}};
  int b_def [NUM_NEURONS] = '{0, -50, 100, 0};

  task automatic load_layer();
    for (int n = 0; n < NUM_NEURONS; n++) begin
      for (int i = 0; i < INPUT_WIDTH; i++) wr(n, i, w_def[n][i]);
      wr(n, INPUT_WIDTH, b_def[n]);
    end
  endtask

  task automatic start_run(input int a0, input int a1, input int a2);
    @(negedge clk);
    a_vec[0] = DATA_W'(a0); a_vec[1] = DATA_W'(a1); a_vec[2] = DATA_W'(a2);
    run_base = vin_total; done_base = done_total;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns one cycle after the DONE cycle, so done_total already includes it.
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int a [INPUT_WIDTH];
    int lat;
    int drop;
    int z [NUM_NEURONS];
    logic terr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a: '{-5, 3, -2},    lat: 1, drop: -1, z: '{-20, -45, 127, 4},     terr: 1'b0};
    tbl[1] = '{a: '{1, 1, 1},      lat: 3, drop: -1, z: '{9, -56, 97, 5},        terr: 1'b0};
    tbl[2] = '{a: '{-5, 3, -2},    lat: 1, drop: 2,  z: '{-20, -45, 0, 4},       terr: 1'b1};
    tbl[3] = '{a: '{100, -100, 10}, lat: 2, drop: -1, z: '{230, 20, -440, -210}, terr: 1'b0};
    tbl[4] = '{a: '{0, 0, 0},      lat: 1, drop: -1, z: '{0, -50, 100, 0},       terr: 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid_in", 64'(n_valid_in), 64'd0);
    check("rst_terr", 64'(timeout_err), 64'd0);
    check("rst_z_out", 64'(z_out), 64'd0);
    check("rst_operands", 64'({n_a_in, n_w_in, n_bias}), 64'd0);

    // Only neuron 0 programmed; zero activations expose the bias alone.
    wr(0, 0, 5); wr(0, 1, 6); wr(0, 2, 7); wr(0, 3, 15);
    start_run(0, 0, 0);
    wait_done("t1");
    check("t1_z0", 64'($signed(z_out[0])), 64'd15);
    check("t1_z1", 64'($signed(z_out[1])), 64'd0);
    check("t1_terr", 64'(timeout_err), 64'd0);
    check("t1_done_count", 64'(done_total - done_base), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    load_layer();
    for (int r = 0; r < 5; r++) begin
      lat = tbl[r].lat; drop_idx = tbl[r].drop;
      start_run(tbl[r].a[0], tbl[r].a[1], tbl[r].a[2]);
      wait_done($sformatf("row%0d", r));
      for (int n = 0; n < NUM_NEURONS; n++)
        check($sformatf("row%0d_z%0d", r, n), 64'($signed(z_out[n])), 64'($signed(tbl[r].z[n])));
      check($sformatf("row%0d_terr", r), 64'(timeout_err), 64'(tbl[r].terr));
      check($sformatf("row%0d_vin_pulses", r), 64'(vin_total - run_base), 64'(NUM_NEURONS));
      check($sformatf("row%0d_done_count", r), 64'(done_total - done_base), 64'd1);
    end
    drop_idx = -1; lat = 1;
    check("vin_one_cycle", 64'(vin_double), 64'd0);

    // Results and error flag hold in IDLE; a stray valid_out is ignored.
    repeat (3) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    check("hold_z1", 64'($signed(z_out[1])), 64'(-50));
    check("stray_vout_z3", 64'($signed(z_out[3])), 64'd0);

    // start + write during busy are both ignored.
    start_run(-5, 3, -2);
    start = 1'b1; a_vec[0] = 16'sd7; a_vec[1] = 16'sd7; a_vec[2] = 16'sd7;
    wr_en = 1'b1; wr_neuron = 2'd1; wr_idx = 2'd0; wr_data = 16'sd99;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done("busy_ign");
    check("busy_ign_z0", 64'($signed(z_out[0])), 64'(-20));
    check("busy_ign_z1", 64'($signed(z_out[1])), 64'(-45));
    check("busy_ign_z2", 64'($signed(z_out[2])), 64'd127);
    check("busy_ign_done_count", 64'(done_total - done_base), 64'd1);

    // Write in the same cycle as start lands before the first issue.
    @(negedge clk);
    a_vec[0] = -16'sd5; a_vec[1] = 16'sd3; a_vec[2] = -16'sd2;
    run_base = vin_total; done_base = done_total;
    start = 1'b1; wr_en = 1'b1; wr_neuron = 2'd0; wr_idx = 2'd3; wr_data = 16'sd1000;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    wait_done("same_cyc");
    check("same_cyc_z0", 64'($signed(z_out[0])), 64'd980);
    check("same_cyc_z3", 64'($signed(z_out[3])), 64'd4);
    wr(0, 3, 0);

    // Asynchronous reset while waiting on neuron 1.
    lat = 6;
    start_run(-5, 3, -2);
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (vin_total - run_base == 2) begin reached = 1'b1; break; end
      end
      check("rst_mid_reach_wait", 64'(reached), 64'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid_in", 64'(n_valid_in), 64'd0);
    check("rst_mid_z_out", 64'(z_out), 64'd0);
    check("rst_mid_terr_done", 64'({timeout_err, done}), 64'd0);
    check("rst_mid_operands", 64'({n_a_in, n_w_in, n_bias}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", 64'(done_total - done_base), 64'd0);
    check("rst_mid_idle", 64'(busy), 64'd0);

    lat = 1;
    load_layer();
    start_run(-5, 3, -2);
    wait_done("post_rst");
    for (int n = 0; n < NUM_NEURONS; n++)
      check($sformatf("post_rst_z%0d", n), 64'($signed(z_out[n])), 64'($signed(tbl[0].z[n])));
    check("post_rst_terr", 64'(timeout_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
